// File: rtl/fir_pkg.sv
// Shared sample types and Q1.15 constants for the FIR datapath and its decimating output stage.
package fir_pkg;
    localparam int SAMPLE_W = 16;
    typedef logic signed [SAMPLE_W-1:0] sample_t;

    localparam sample_t Q15_POS_ONE = 16'h7FFF;
    localparam sample_t Q15_NEG_ONE = 16'h8000;

    localparam int PHASE_W = 5;
    localparam int DROP_W  = 8;
    localparam logic [DROP_W-1:0] DROP_MAX = 8'hFF;
endpackage

// File: rtl/sync_fifo.sv
// First-word fall-through FIFO; head, empty and full are held in registers so the outputs are flop-driven.
module sync_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [CW-1:0]    count_r;
    logic [WIDTH-1:0] head_r;
    logic             empty_r;
    logic             full_r;

    logic             push_s;
    logic             pop_s;
    logic [AW-1:0]    wr_next_s;
    logic [AW-1:0]    rd_next_s;
    logic [CW-1:0]    cnt_next_s;
    logic [WIDTH-1:0] head_next_s;

    // Next-state pointers, occupancy and the sample that will sit at the head after this edge.
    always_comb begin
        pop_s     = pop && !empty_r;
        push_s    = push && (!full_r || pop_s);
        rd_next_s = rd_ptr_r + AW'(pop_s);
        wr_next_s = wr_ptr_r + AW'(push_s);
        case ({push_s, pop_s})
            2'b10:   cnt_next_s = count_r + CW'(1);
            2'b01:   cnt_next_s = count_r - CW'(1);
            default: cnt_next_s = count_r;
        endcase
        // A push into a slot that becomes the head must bypass the array, which updates at the same edge.
        if (cnt_next_s == {CW{1'b0}}) begin
            head_next_s = {WIDTH{1'b0}};
        end else if (push_s && (wr_ptr_r == rd_next_s)) begin
            head_next_s = din;
        end else begin
            head_next_s = mem_r[rd_next_s];
        end
    end

    // Storage array; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= din;
        end
    end

    // Pointer, occupancy and registered status/head state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
            head_r   <= {WIDTH{1'b0}};
            empty_r  <= 1'b1;
            full_r   <= 1'b0;
        end else begin
            wr_ptr_r <= wr_next_s;
            rd_ptr_r <= rd_next_s;
            count_r  <= cnt_next_s;
            head_r   <= head_next_s;
            empty_r  <= (cnt_next_s == {CW{1'b0}});
            full_r   <= (cnt_next_s == CW'(DEPTH));
        end
    end

    assign dout  = head_r;
    assign empty = empty_r;
    assign full  = full_r;
    assign count = count_r;
endmodule

// File: rtl/fir_decim.sv
// Decimator behind the FIR: keeps one of every DECIM samples and buffers kept samples for a
// ready/valid consumer, counting samples lost when the buffer is full.
module fir_decim
    import fir_pkg::*;
#(
    parameter int DECIM = 2,
    parameter int DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              valid_in,
    input  sample_t           data_in,
    input  logic              clr_ovf,
    output logic              out_valid,
    input  logic              out_ready,
    output sample_t           out_data,
    output logic              overflow,
    output logic [DROP_W-1:0] drop_cnt
);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [PHASE_W-1:0] PHASE_LAST = PHASE_W'(DECIM - 1);
    localparam logic [CW-1:0]      CNT_DEPTH  = CW'(DEPTH);

    logic [PHASE_W-1:0] phase_r;
    logic [PHASE_W-1:0] phase_next_s;
    logic               overflow_r;
    logic [DROP_W-1:0]  drop_cnt_r;

    logic               kept_s;
    logic               pop_s;
    logic               push_s;
    logic               drop_s;
    logic               fifo_full_s;
    logic               fifo_empty_s;
    logic [CW-1:0]      fifo_count_s;
    logic [SAMPLE_W-1:0] fifo_dout_s;

    // Phase advance and keep/push/drop decision for the incoming sample.
    always_comb begin
        kept_s = valid_in && (phase_r == {PHASE_W{1'b0}});
        if (!valid_in) begin
            phase_next_s = phase_r;
        end else if (phase_r == PHASE_LAST) begin
            phase_next_s = {PHASE_W{1'b0}};
        end else begin
            phase_next_s = phase_r + PHASE_W'(1);
        end
        pop_s  = !fifo_empty_s && out_ready;
        // Room exists when not full, or when the head leaves in the same cycle.
        push_s = kept_s && ((fifo_count_s < CNT_DEPTH) || pop_s);
        drop_s = kept_s && fifo_full_s && !pop_s;
    end

    // Phase counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_r <= {PHASE_W{1'b0}};
        end else begin
            phase_r <= phase_next_s;
        end
    end

    // Sticky overflow and saturating drop counter; a drop in the clear cycle wins over the clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow_r <= 1'b0;
            drop_cnt_r <= {DROP_W{1'b0}};
        end else if (clr_ovf) begin
            overflow_r <= drop_s;
            drop_cnt_r <= drop_s ? DROP_W'(1) : {DROP_W{1'b0}};
        end else if (drop_s) begin
            overflow_r <= 1'b1;
            drop_cnt_r <= (drop_cnt_r == DROP_MAX) ? DROP_MAX : (drop_cnt_r + DROP_W'(1));
        end
    end

    sync_fifo #(
        .WIDTH (SAMPLE_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push_s),
        .pop   (pop_s),
        .din   (data_in),
        .dout  (fifo_dout_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s),
        .count (fifo_count_s)
    );

    assign out_valid = !fifo_empty_s;
    assign out_data  = fifo_dout_s;
    assign overflow  = overflow_r;
    assign drop_cnt  = drop_cnt_r;
endmodule
